// File: rtl/dot8_row_accum.sv
// Sums a run-time number of consecutive dot8 partials into one row result and queues the
// completed row sums in a small FIFO drained over a valid/ready handshake.
module dot8_row_accum #(
    parameter int unsigned IWIDTH = 32,
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned CWIDTH = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CWIDTH-1:0] num_chunks,
    input  logic              clear,
    input  logic              ivalid,
    input  logic [IWIDTH-1:0] idata,
    output logic [AWIDTH-1:0] odata,
    output logic              ovalid,
    input  logic              oready,
    output logic              afull,
    output logic              busy,
    output logic              ovf
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [AWIDTH-1:0] acc_q;
    logic [CWIDTH-1:0] cnt_q;
    logic [CWIDTH-1:0] n_lat_q;
    logic [AWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW:0]       occ_q;
    logic              ovf_q;

    logic [CWIDTH-1:0] n_eff;
    logic [AWIDTH-1:0] idata_ext;
    logic [AWIDTH-1:0] acc_next;
    logic              last;
    logic              push;
    logic              pop;
    logic              full;
    logic              push_ok;

    assign idata_ext = AWIDTH'($signed(idata));

    // Row length is latched on the first partial; mid-row changes to num_chunks are ignored.
    always_comb begin
        n_eff = n_lat_q;
        if (cnt_q == '0) begin
            n_eff = (num_chunks == '0) ? CWIDTH'(1) : num_chunks;
        end
    end

    assign acc_next = ((cnt_q == '0) ? '0 : acc_q) + idata_ext;
    assign last     = ({1'b0, cnt_q} + (CWIDTH + 1)'(1)) == {1'b0, n_eff};
    assign push     = ivalid && !clear && last;

    assign ovalid  = (occ_q != '0);
    assign full    = (occ_q == (PW + 1)'(DEPTH));
    assign afull   = (occ_q >= (PW + 1)'(DEPTH - 1));
    assign pop     = ovalid && oready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);

    assign odata = ovalid ? mem[rd_ptr_q] : '0;
    assign busy  = (cnt_q != '0);
    assign ovf   = ovf_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            n_lat_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (clear) begin
                cnt_q <= '0;
                acc_q <= '0;
            end else if (ivalid) begin
                if (cnt_q == '0) begin
                    n_lat_q <= n_eff;
                end
                if (last) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CWIDTH'(1);
                    acc_q <= acc_next;
                end
            end

            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (push && !push_ok) begin
                ovf_q <= 1'b1;
            end
            occ_q <= occ_q + (PW + 1)'(push_ok) - (PW + 1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push_ok) begin
            mem[wr_ptr_q] <= acc_next;
        end
    end

endmodule

// File: tb/tb_dot8_row_accum.sv
// Directed row-accumulation scenarios plus random traffic, checked against a queue-based model.
module tb_dot8_row_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  num_chunks;
    logic        clear;
    logic        ivalid;
    logic [31:0] idata;
    logic [31:0] odata;
    logic        ovalid;
    logic        oready;
    logic        afull;
    logic        busy;
    logic        ovf;

    int nvec = 0;
    int nerr = 0;

    // Reference model: plain row arithmetic and a bounded queue of completed sums.
    int          m_cnt;
    int          m_n;
    logic [31:0] m_sum;
    logic [31:0] m_q[$];
    logic        m_ovf;

    dot8_row_accum #(
        .IWIDTH(32),
        .AWIDTH(32),
        .CWIDTH(8),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .num_chunks(num_chunks),
        .clear     (clear),
        .ivalid    (ivalid),
        .idata     (idata),
        .odata     (odata),
        .ovalid    (ovalid),
        .oready    (oready),
        .afull     (afull),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_n   = 0;
        m_sum = '0;
        m_q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_edge();
        logic        do_pop;
        logic        do_push;
        logic [31:0] val;
        do_pop  = (m_q.size() > 0) && oready;
        do_push = 1'b0;
        val     = '0;
        if (!rst) begin
            model_reset();
        end else begin
            if (clear) begin
                m_cnt = 0;
                m_sum = '0;
            end else if (ivalid) begin
                if (m_cnt == 0) begin
                    m_n   = (num_chunks == 0) ? 1 : int'(num_chunks);
                    m_sum = idata;
                end else begin
                    m_sum = m_sum + idata;
                end
                m_cnt++;
                if (m_cnt == m_n) begin
                    do_push = 1'b1;
                    val     = m_sum;
                    m_cnt   = 0;
                end
            end
            if (do_push && m_q.size() == 4 && !do_pop) begin
                m_ovf = 1'b1;
                do_push = 1'b0;
            end
            if (do_pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back(val);
        end
    endtask

    // Check every output against the model mid-cycle, then advance both across the edge.
    task automatic tick();
        @(negedge clk);
        check("ovalid", ovalid, m_q.size() > 0);
        check("odata", odata, (m_q.size() > 0) ? m_q[0] : 32'h0);
        check("afull", afull, m_q.size() >= 3);
        check("busy", busy, m_cnt != 0);
        check("ovf", ovf, m_ovf);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic c, input logic v, input logic [31:0] d,
                         input logic [7:0] n, input logic rdy);
        rst        = r;
        clear      = c;
        ivalid     = v;
        idata      = d;
        num_chunks = n;
        oready     = rdy;
        tick();
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 8'd1, 1'b0);
    endtask

    initial begin
        model_reset();
        rst = 1'b0; clear = 1'b0; ivalid = 1'b0; idata = '0; num_chunks = 8'd1; oready = 1'b0;
        #1;
        do_reset();
        check("reset_ovalid", ovalid, 1'b0);
        check("reset_odata", odata, 32'h0);
        check("reset_busy", busy, 1'b0);

        // Single-chunk rows stream straight through.
        drive(1'b1, 1'b0, 1'b1, 32'd5, 8'd1, 1'b1);
        check("t1_first", odata, 32'd5);
        check("t1_busy", busy, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFD, 8'd1, 1'b1);
        check("t1_second", odata, 32'hFFFF_FFFD);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 8'd1, 1'b1);
        check("t1_drained", ovalid, 1'b0);

        // Three-chunk row and 32-bit wrap.
        drive(1'b1, 1'b0, 1'b1, 32'd129032, 8'd3, 1'b0);
        check("t2_busy1", busy, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 32'd131072, 8'd9, 1'b0);
        check("t2_busy2", busy, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 32'd120, 8'd9, 1'b0);
        check("t2_sum", odata, 32'd260224);
        check("t2_idle", busy, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 32'h7FFF_FFFF, 8'd2, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 32'h1, 8'd2, 1'b1);
        check("t2_wrap", odata, 32'h8000_0000);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 8'd1, 1'b1);

        // Overflow while stalled, then drain in order.
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b0, 1'b1, 32'(i * 10), 8'd1, 1'b0);
            if (i == 3) check("t3_afull", afull, 1'b1);
        end
        check("t3_ovf", ovf, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            check("t3_order", odata, 32'(i * 10));
            drive(1'b1, 1'b0, 1'b0, 32'h0, 8'd1, 1'b1);
        end
        check("t3_empty", ovalid, 1'b0);

        // Push into a full FIFO while its head pops.
        do_reset();
        for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, 1'b1, 32'(i), 8'd1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 32'd5, 8'd1, 1'b1);
        check("t4_ovf", ovf, 1'b0);
        check("t4_head", odata, 32'd2);
        check("t4_afull", afull, 1'b1);
        for (int i = 2; i <= 5; i++) begin
            check("t4_order", odata, 32'(i));
            drive(1'b1, 1'b0, 1'b0, 32'h0, 8'd1, 1'b1);
        end

        // Clear aborts a row and discards the coincident partial.
        drive(1'b1, 1'b0, 1'b1, 32'd7, 8'd4, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 32'd7, 8'd4, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 32'd7, 8'd4, 1'b0);
        check("t5_cleared", busy, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 32'd1, 8'd4, 1'b0);
        check("t5_sum", odata, 32'd4);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 8'd4, 1'b1);
        check("t5_single", ovalid, 1'b0);

        // Reset with FIFO occupied and a row in flight.
        drive(1'b1, 1'b0, 1'b1, 32'd1, 8'd1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 32'd2, 8'd1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 32'd5, 8'd3, 1'b0);
        do_reset();
        check("t6_ovalid", ovalid, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_afull", afull, 1'b0);
        check("t6_ovf", ovf, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 32'd9, 8'd1, 1'b0);
        check("t6_sum", odata, 32'd9);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) != 0), $urandom(), 8'($urandom_range(0, 5)),
                  ($urandom_range(0, 1) == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
